io_bus_gen2: RTL

Second-generation CPU I/O bus: one CPU load/store port fanned out to NSLV parametrised memory-mapped slave channels, each with base/mask decode and a ready handshake with timeout. It also hosts a local register bank holding seg7 value, VGA mode/colours and switch readback, plus a KBD_DEPTH scancode FIFO with its own keyboard ack handshake. It sits between the pipeline CPU data port and RAM/VRAM/ROM/peripherals, and replaces the fixed-map, zero-wait bus.

---
 rtl/io_bus_gen2.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/io_bus_gen2.sv
// io_bus_gen2: CPU load/store port fanned out to decoded slave channels with ready/timeout, plus local registers and keyboard FIFO.
module io_bus_gen2 #(
    parameter int                   NSLV       = 4,
    parameter int                   DW         = 32,
    parameter logic [NSLV*32-1:0]   SLV_BASE   = {32'h0000_0000, 32'h000C_0000, 32'h1000_0000, 32'h2000_0000},
    parameter logic [NSLV*32-1:0]   SLV_MASK   = {32'hFFFF_C000, 32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [31:0]          LOCAL_BASE = 32'hF000_0000,
    parameter int                   TIMEOUT    = 15,
    parameter int                   KBD_DEPTH  = 8,
    parameter logic [DW-1:0]        ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic [31:0]          cpu_addr,
    input  logic [3:0]           cpu_be,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic [NSLV-1:0]      slv_sel,
    output logic [31:0]          slv_addr,
    output logic [3:0]           slv_be,
    output logic [DW-1:0]        slv_wdata,
    input  logic [NSLV*DW-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready,
    input  logic [15:0]          switch,
    output logic [31:0]          seg7led,
    output logic                 vga_mode,
    output logic [11:0]          forecolor,
    output logic [11:0]          backcolor,
    input  logic                 kbd_ready,
    input  logic [7:0]           kbd_code,
    output logic                 kbd_read
);
    localparam int AW = $clog2(KBD_DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;

    logic [1:0]      state;
    logic [NSLV-1:0] sel_q, hit;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   rdata_q, slv_mux;
    logic            err_q, ovf;
    logic [31:0]     loc_rd;
    logic [7:0]      mem [KBD_DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [AW:0]     count;

    wire local_hit = (cpu_addr & 32'hFFFF_FFC0) == LOCAL_BASE;
    wire loc_op    = state == IDLE && cpu_req && local_hit;
    wire wr        = cpu_be != 4'b0;
    wire [3:0] ofs = cpu_addr[5:2];
    wire empty     = count == '0;
    wire full      = count == (AW+1)'(KBD_DEPTH);
    wire pop       = loc_op && !wr && ofs == 4'h5 && !empty;
    wire push_req  = kbd_ready && !kbd_read;
    wire push      = push_req && (!full || pop);
    wire ovf_set   = push_req && full && !pop;
    wire ovf_clr   = loc_op && wr && ofs == 4'h4 && cpu_be[0] && cpu_wdata[1];
    wire ready_hit = |(sel_q & slv_ready);

    assign cpu_ack   = state == RESP;
    assign cpu_err   = state == RESP && err_q;
    assign cpu_rdata = rdata_q;
    assign slv_sel   = state == ACCESS ? sel_q : '0;

    // Iterate high to low so the lowest matching slot wins.
    always_comb begin
        hit = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if ((cpu_addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32])
                hit = NSLV'(1) << i;
    end

    always_comb begin
        slv_mux = '0;
        for (int i = 0; i < NSLV; i++)
            if (sel_q[i])
                slv_mux |= slv_rdata[i*DW +: DW];
    end

    always_comb begin
        loc_rd = ofs == 4'h0 ? seg7led :
                 ofs == 4'h1 ? {31'b0, vga_mode} :
                 ofs == 4'h2 ? {20'b0, forecolor} :
                 ofs == 4'h3 ? {20'b0, backcolor} :
                 ofs == 4'h4 ? {16'b0, 8'(count), 6'b0, ovf, !empty} :
                 ofs == 4'h5 ? {24'b0, empty ? 8'b0 : mem[rp]} :
                 ofs == 4'h6 ? {16'b0, switch} : 32'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            slv_addr  <= '0;
            slv_be    <= '0;
            slv_wdata <= '0;
        end else if (state == IDLE) begin
            if (cpu_req) begin
                slv_addr  <= cpu_addr;
                slv_be    <= cpu_be;
                slv_wdata <= cpu_wdata;
                cnt       <= '0;
                if (local_hit) begin
                    state   <= RESP;
                    err_q   <= 1'b0;
                    rdata_q <= wr ? '0 : DW'(loc_rd);
                end else if (|hit) begin
                    state <= ACCESS;
                    sel_q <= hit;
                    err_q <= 1'b0;
                end else begin
                    state   <= RESP;
                    err_q   <= 1'b1;
                    rdata_q <= ERR_RDATA;
                end
            end
        end else if (state == ACCESS) begin
            if (ready_hit) begin
                state   <= RESP;
                rdata_q <= slv_be != 4'b0 ? '0 : slv_mux;
            end else if (cnt == CW'(TIMEOUT)) begin
                state   <= RESP;
                err_q   <= 1'b1;
                rdata_q <= ERR_RDATA;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg7led   <= '0;
            vga_mode  <= 1'b0;
            forecolor <= '0;
            backcolor <= '0;
        end else if (loc_op && wr) begin
            for (int b = 0; b < 4; b++)
                if (ofs == 4'h0 && cpu_be[b])
                    seg7led[b*8 +: 8] <= cpu_wdata[b*8 +: 8];
            if (ofs == 4'h1 && cpu_be[0])
                vga_mode <= cpu_wdata[0];
            if (ofs == 4'h2 && cpu_be[0])
                forecolor[7:0] <= cpu_wdata[7:0];
            if (ofs == 4'h2 && cpu_be[1])
                forecolor[11:8] <= cpu_wdata[11:8];
            if (ofs == 4'h3 && cpu_be[0])
                backcolor[7:0] <= cpu_wdata[7:0];
            if (ofs == 4'h3 && cpu_be[1])
                backcolor[11:8] <= cpu_wdata[11:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            kbd_read <= 1'b0;
        end else begin
            kbd_read <= push_req;
            wp       <= push ? wp + 1'b1 : wp;
            rp       <= pop ? rp + 1'b1 : rp;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            ovf      <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
        end
    end

    always_ff @(posedge clk)
        if (push)
            mem[wp] <= kbd_code;
endmodule
